// File: rtl/ad_cap_pkg.sv
// rtl/ad_cap_pkg.sv - shared FSM type and sizing helpers for the ADC capture block
package ad_cap_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } cap_state_t;

  // Total sclk periods per conversion frame
  function automatic int frame_bits(input int lead, input int dw);
    return lead + dw;
  endfunction

  // Bits needed for a counter that must reach maxv
  function automatic int cnt_w(input int maxv);
    return (maxv < 2) ? 1 : $clog2(maxv + 1);
  endfunction

endpackage

// File: rtl/ad_sclk_gen.sv
// rtl/ad_sclk_gen.sv - half-period timer, sclk flop and rise strobe
module ad_sclk_gen
  import ad_cap_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic mclk,
  input  logic hrst,
  input  logic run,
  input  logic toggle_en,
  output logic sclk,
  output logic tick,
  output logic rise
);

  localparam int HW = cnt_w(DIV - 1);
  localparam logic [HW-1:0] HMAX = HW'(DIV - 1);

  logic [HW-1:0] hcnt;

  // tick marks the last mclk cycle of a DIV-long phase
  assign tick = run && (hcnt == HMAX);
  assign rise = tick && toggle_en && !sclk;

  // Half-period counter runs only while a frame is active
  always_ff @(posedge mclk or posedge hrst) begin
    if (hrst) begin
      hcnt <= '0;
    end else if (!run || tick) begin
      hcnt <= '0;
    end else begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // sclk idles high and toggles only at phase ends the FSM allows
  always_ff @(posedge mclk or posedge hrst) begin
    if (hrst) begin
      sclk <= 1'b1;
    end else if (!run) begin
      sclk <= 1'b1;
    end else if (tick && toggle_en) begin
      sclk <= ~sclk;
    end
  end

endmodule

// File: rtl/ad_cap_mc.sv
// rtl/ad_cap_mc.sv - periodic multi-channel serial ADC capture controller
module ad_cap_mc
  import ad_cap_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DW     = 12,
  parameter int LEAD   = 4,
  parameter int DIV    = 4,
  parameter int PERIOD = 200
) (
  input  logic                mclk,
  input  logic                hrst,
  input  logic                en,
  output logic                cs_n,
  output logic                sclk,
  input  logic [NCH-1:0]      sdata,
  output logic [NCH*DW-1:0]   smp_data,
  output logic                smp_vld,
  input  logic                smp_rdy,
  output logic                ovr,
  input  logic                ovr_clr,
  output logic                busy
);

  localparam int FB = frame_bits(LEAD, DW);
  localparam int PW = cnt_w(PERIOD - 1);
  localparam int BW = cnt_w(FB);
  localparam logic [PW-1:0] PMAX = PW'(PERIOD - 1);
  localparam logic [BW-1:0] BMAX = BW'(FB);

  if (NCH < 1 || NCH > 8) begin : g_bad_nch
    $error("ad_cap_mc: NCH must be within 1..8");
  end
  if (DIV < 2) begin : g_bad_div
    $error("ad_cap_mc: DIV must be at least 2");
  end
  if (2 * DIV + 2 * DIV * FB > PERIOD) begin : g_bad_period
    $error("ad_cap_mc: PERIOD too short for one frame");
  end

  cap_state_t          state, state_nxt;
  logic [PW-1:0]       pcnt;
  logic [BW-1:0]       bcnt;
  logic                run, tick, rise, toggle_en, last_hi;
  logic                hold_entry, load;
  logic [NCH*DW-1:0]   cap_word;

  assign run        = (state != IDLE);
  assign hold_entry = (state == SHIFT) && (state_nxt == HOLD);
  assign load       = hold_entry && (!smp_vld || smp_rdy);

  ad_sclk_gen #(
    .DIV(DIV)
  ) u_sclk (
    .mclk      (mclk),
    .hrst      (hrst),
    .run       (run),
    .toggle_en (toggle_en),
    .sclk      (sclk),
    .tick      (tick),
    .rise      (rise)
  );

  // Frame-start timer; parked at zero while disabled so enable starts a frame at once
  always_ff @(posedge mclk or posedge hrst) begin
    if (hrst) begin
      pcnt <= '0;
    end else if (!en || pcnt == PMAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge mclk or posedge hrst) begin
    if (hrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and sclk toggle permission; the final high phase must not toggle
  always_comb begin
    state_nxt = state;
    last_hi   = (state == SHIFT) && sclk && (bcnt == BMAX);
    toggle_en = (state == SETUP) || ((state == SHIFT) && !last_hi);
    case (state)
      IDLE:    if (en && pcnt == '0) state_nxt = SETUP;
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && last_hi) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counts sclk rises within the shift phase
  always_ff @(posedge mclk or posedge hrst) begin
    if (hrst) begin
      bcnt <= '0;
    end else if (state != SHIFT) begin
      bcnt <= '0;
    end else if (rise) begin
      bcnt <= bcnt + 1'b1;
    end
  end

  // cs_n and busy come from next state so cs_n falls on the SETUP entry edge
  always_ff @(posedge mclk or posedge hrst) begin
    if (hrst) begin
      cs_n <= 1'b1;
      busy <= 1'b0;
    end else begin
      cs_n <= (state_nxt == IDLE);
      busy <= (state_nxt != IDLE);
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DW-1:0] sr;
    // MSB-first capture on each sclk rise; lead bits fall off the top
    always_ff @(posedge mclk or posedge hrst) begin
      if (hrst) begin
        sr <= '0;
      end else if (rise) begin
        sr <= {sr[DW-2:0], sdata[k]};
      end
    end
    assign cap_word[k*DW +: DW] = sr;
  end

  // Output word handshake; a fresh sample may replace one being accepted this cycle
  always_ff @(posedge mclk or posedge hrst) begin
    if (hrst) begin
      smp_data <= '0;
      smp_vld  <= 1'b0;
    end else if (load) begin
      smp_data <= cap_word;
      smp_vld  <= 1'b1;
    end else if (smp_rdy) begin
      smp_vld  <= 1'b0;
    end
  end

  // Sticky overrun; a new overrun wins over a clear in the same cycle
  always_ff @(posedge mclk or posedge hrst) begin
    if (hrst) begin
      ovr <= 1'b0;
    end else if (hold_entry && smp_vld && !smp_rdy) begin
      ovr <= 1'b1;
    end else if (ovr_clr) begin
      ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ad_cap_mc.sv
// tb/tb_ad_cap_mc.sv - self-checking bench for ad_cap_mc
module tb_ad_cap_mc;

  logic mclk = 1'b0;
  always #5 mclk = ~mclk;

  logic        hrst;
  logic        en_a, cs_n_a, sclk_a, smp_vld_a, smp_rdy_a, ovr_a, ovr_clr_a, busy_a;
  logic [1:0]  sdata_a;
  logic [23:0] smp_data_a;
  logic        en_b, cs_n_b, sclk_b, smp_vld_b, smp_rdy_b, ovr_b, ovr_clr_b, busy_b;
  logic [3:0]  sdata_b;
  logic [31:0] smp_data_b;

  ad_cap_mc #(.NCH(2), .DW(12), .LEAD(4), .DIV(4), .PERIOD(200)) dut_a (
    .mclk(mclk), .hrst(hrst), .en(en_a), .cs_n(cs_n_a), .sclk(sclk_a),
    .sdata(sdata_a), .smp_data(smp_data_a), .smp_vld(smp_vld_a),
    .smp_rdy(smp_rdy_a), .ovr(ovr_a), .ovr_clr(ovr_clr_a), .busy(busy_a)
  );

  ad_cap_mc #(.NCH(4), .DW(8), .LEAD(0), .DIV(2), .PERIOD(40)) dut_b (
    .mclk(mclk), .hrst(hrst), .en(en_b), .cs_n(cs_n_b), .sclk(sclk_b),
    .sdata(sdata_b), .smp_data(smp_data_b), .smp_vld(smp_vld_b),
    .smp_rdy(smp_rdy_b), .ovr(ovr_b), .ovr_clr(ovr_clr_b), .busy(busy_b)
  );

  typedef struct {
    logic [11:0] v0, v1, v2, v3;
    logic [31:0] exp_data;
    int          exp_low;
  } vec_t;

  vec_t        tab_a [4];
  vec_t        tab_b [2];
  logic [11:0] adc_a [2];
  logic [7:0]  adc_b [4];
  int idx_a, idx_b, rise_b, cyc;
  int checks = 0;
  int errors = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  // ADC A: 4 zero lead bits then 12 data bits, next bit driven on sclk fall
  always @(negedge sclk_a or negedge cs_n_a) begin
    if (!cs_n_a && sclk_a) begin
      idx_a = 0;
    end else if (!cs_n_a && !sclk_a) begin
      for (int c = 0; c < 2; c++)
        sdata_a[c] = (idx_a >= 4 && idx_a < 16) ? adc_a[c][15 - idx_a] : 1'b0;
      idx_a = idx_a + 1;
    end
  end

  // ADC B: 8 data bits, no lead
  always @(negedge sclk_b or negedge cs_n_b) begin
    if (!cs_n_b && sclk_b) begin
      idx_b = 0;
    end else if (!cs_n_b && !sclk_b) begin
      for (int c = 0; c < 4; c++)
        sdata_b[c] = (idx_b < 8) ? adc_b[c][7 - idx_b] : 1'b0;
      idx_b = idx_b + 1;
    end
  end

  always @(posedge sclk_b) if (!cs_n_b) rise_b = rise_b + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_adc(input bit sel, input vec_t v);
    if (sel) begin
      adc_b[0] = v.v0[7:0]; adc_b[1] = v.v1[7:0];
      adc_b[2] = v.v2[7:0]; adc_b[3] = v.v3[7:0];
    end else begin
      adc_a[0] = v.v0; adc_a[1] = v.v1;
    end
  endtask

  task automatic wait_fall(input bit sel);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge mclk);
      ok = sel ? !cs_n_b : !cs_n_a;
    end
    chk(sel ? "cs_n_b fall seen" : "cs_n_a fall seen", {31'd0, ok}, 32'd1);
  endtask

  // Counts remaining low cycles from the current negedge; returns at first high cs_n
  task automatic finish_frame(input bit sel, output int low, output int nvld,
                              output logic [31:0] data, output int vcyc);
    low = 0; nvld = 0; data = '0; vcyc = 0;
    while ((sel ? !cs_n_b : !cs_n_a) && low < 400) begin
      low++;
      if (sel ? smp_vld_b : smp_vld_a) begin
        if (nvld == 0) begin
          data = sel ? smp_data_b : {8'h00, smp_data_a};
          vcyc = cyc;
        end
        nvld++;
      end
      @(negedge mclk);
    end
  endtask

  initial begin
    int low, nvld, vcyc, prev_vcyc, r0, stray;
    logic [31:0] data;

    tab_a[0] = '{12'hABC, 12'h123, 12'h000, 12'h000, 32'h00123ABC, 136};
    tab_a[1] = '{12'hFFF, 12'h000, 12'h000, 12'h000, 32'h00000FFF, 136};
    tab_a[2] = '{12'h000, 12'hFFF, 12'h000, 12'h000, 32'h00FFF000, 136};
    tab_a[3] = '{12'h555, 12'hAAA, 12'h000, 12'h000, 32'h00AAA555, 136};
    tab_b[0] = '{12'h05A, 12'h0A5, 12'h0FF, 12'h000, 32'h00FFA55A, 36};
    tab_b[1] = '{12'h001, 12'h080, 12'h03C, 12'h0C3, 32'hC33C8001, 36};

    hrst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    smp_rdy_a = 1'b0; smp_rdy_b = 1'b0; ovr_clr_a = 1'b0; ovr_clr_b = 1'b0;
    adc_a[0] = '0; adc_a[1] = '0;
    for (int c = 0; c < 4; c++) adc_b[c] = '0;
    repeat (3) @(negedge mclk);
    chk("reset cs_n_a", {31'd0, cs_n_a}, 32'd1);
    chk("reset sclk_a", {31'd0, sclk_a}, 32'd1);
    chk("reset smp_vld_a", {31'd0, smp_vld_a}, 32'd0);
    chk("reset ovr_a", {31'd0, ovr_a}, 32'd0);
    chk("reset busy_a", {31'd0, busy_a}, 32'd0);
    chk("reset smp_data_a", {8'h00, smp_data_a}, 32'd0);
    chk("reset cs_n_b", {31'd0, cs_n_b}, 32'd1);
    chk("reset sclk_b", {31'd0, sclk_b}, 32'd1);
    hrst = 1'b0;
    @(negedge mclk);

    // Small configuration: 4 channels, 8 bits, no lead
    smp_rdy_b = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_adc(1'b1, tab_b[i]);
      en_b = 1'b1;
      wait_fall(1'b1);
      r0 = rise_b;
      finish_frame(1'b1, low, nvld, data, vcyc);
      chk($sformatf("b[%0d] smp_data", i), data, tab_b[i].exp_data);
      chk($sformatf("b[%0d] cs_n low cycles", i), low, tab_b[i].exp_low);
      chk($sformatf("b[%0d] sclk rises", i), rise_b - r0, 32'd8);
      chk($sformatf("b[%0d] vld pulses", i), nvld, 32'd1);
    end
    en_b = 1'b0;

    // Default configuration, consumer always ready
    smp_rdy_a = 1'b1;
    prev_vcyc = 0;
    for (int i = 0; i < 4; i++) begin
      set_adc(1'b0, tab_a[i]);
      en_a = 1'b1;
      wait_fall(1'b0);
      finish_frame(1'b0, low, nvld, data, vcyc);
      chk($sformatf("a[%0d] smp_data", i), data, tab_a[i].exp_data);
      chk($sformatf("a[%0d] cs_n low cycles", i), low, tab_a[i].exp_low);
      chk($sformatf("a[%0d] vld pulses", i), nvld, 32'd1);
      if (i > 0) chk($sformatf("a[%0d] vld spacing", i), vcyc - prev_vcyc, 32'd200);
      prev_vcyc = vcyc;
    end

    // Two frames unconsumed: first held, overrun flagged, then cleared
    smp_rdy_a = 1'b0;
    adc_a[0] = 12'h111; adc_a[1] = 12'h222;
    wait_fall(1'b0);
    finish_frame(1'b0, low, nvld, data, vcyc);
    chk("ovr frame1 data", data, 32'h00222111);
    chk("ovr frame1 ovr", {31'd0, ovr_a}, 32'd0);
    adc_a[0] = 12'h333; adc_a[1] = 12'h444;
    wait_fall(1'b0);
    finish_frame(1'b0, low, nvld, data, vcyc);
    chk("ovr frame2 data held", {8'h00, smp_data_a}, 32'h00222111);
    chk("ovr frame2 vld", {31'd0, smp_vld_a}, 32'd1);
    chk("ovr frame2 ovr set", {31'd0, ovr_a}, 32'd1);
    ovr_clr_a = 1'b1;
    @(negedge mclk);
    ovr_clr_a = 1'b0;
    chk("ovr cleared", {31'd0, ovr_a}, 32'd0);

    // Consumer accepts in the very cycle HOLD is entered: reload, no overrun
    adc_a[0] = 12'h456; adc_a[1] = 12'h789;
    wait_fall(1'b0);
    repeat (131) @(negedge mclk);
    smp_rdy_a = 1'b1;
    @(negedge mclk);
    chk("reload vld", {31'd0, smp_vld_a}, 32'd1);
    chk("reload data", {8'h00, smp_data_a}, 32'h00789456);
    chk("reload ovr", {31'd0, ovr_a}, 32'd0);
    finish_frame(1'b0, low, nvld, data, vcyc);
    chk("drained vld", {31'd0, smp_vld_a}, 32'd0);

    // en dropped mid-frame: frame completes, then no further frames
    smp_rdy_a = 1'b0;
    adc_a[0] = 12'hFED; adc_a[1] = 12'h0F0;
    wait_fall(1'b0);
    repeat (40) @(negedge mclk);
    en_a = 1'b0;
    finish_frame(1'b0, low, nvld, data, vcyc);
    chk("en drop remaining low", low, 32'd96);
    chk("en drop data", data, 32'h000F0FED);
    stray = 0;
    repeat (450) begin
      @(negedge mclk);
      if (!cs_n_a) stray++;
    end
    chk("en drop no new frame", stray, 32'd0);

    // Reset during shift bit 7 (sclk low), then a clean frame after release
    adc_a[0] = 12'h9C3; adc_a[1] = 12'h6A5;
    en_a = 1'b1;
    wait_fall(1'b0);
    repeat (62) @(negedge mclk);
    chk("pre-reset sclk low", {31'd0, sclk_a}, 32'd0);
    hrst = 1'b1;
    #1;
    chk("mid reset cs_n", {31'd0, cs_n_a}, 32'd1);
    chk("mid reset sclk", {31'd0, sclk_a}, 32'd1);
    chk("mid reset smp_vld", {31'd0, smp_vld_a}, 32'd0);
    chk("mid reset busy", {31'd0, busy_a}, 32'd0);
    chk("mid reset smp_data", {8'h00, smp_data_a}, 32'd0);
    repeat (2) @(negedge mclk);
    hrst = 1'b0;
    smp_rdy_a = 1'b1;
    @(negedge mclk);
    chk("post reset first cycle cs_n", {31'd0, cs_n_a}, 32'd0);
    finish_frame(1'b0, low, nvld, data, vcyc);
    chk("post reset data", data, 32'h006A59C3);
    chk("post reset low cycles", low, 32'd136);
    chk("post reset ovr", {31'd0, ovr_a}, 32'd0);
    en_a = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
